// File: rtl/apex_cfg_ctrl.sv
// apex_cfg_ctrl: shadowed ER/OR configuration registers, validated by a 4-step
// sequential checker before being pushed to the live buses feeding hwmod.
module apex_cfg_ctrl #(
    parameter logic [15:0] META_BASE  = 16'h0140,
    parameter logic [15:0] SMEM_BASE  = 16'hA000,
    parameter logic [15:0] SMEM_SIZE  = 16'h4000,
    parameter logic [15:0] ER_MIN_DEF = 16'hE1CC,
    parameter logic [15:0] ER_MAX_DEF = 16'hE6CC,
    parameter logic [15:0] OR_MIN_DEF = 16'hF000,
    parameter logic [15:0] OR_MAX_DEF = 16'hF004
) (
    input  logic        clk,
    input  logic        puc,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    input  logic        dma_en,
    input  logic        exec,
    output logic [15:0] ER_min,
    output logic [15:0] ER_max,
    output logic [15:0] OR_min,
    output logic [15:0] OR_max,
    output logic        cfg_busy,
    output logic        cfg_valid,
    output logic [1:0]  cfg_err
);
    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
    localparam logic [16:0] SMEM_END = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd1;
    state_t      state;
    logic [1:0]  idx;
    logic [15:0] sh_er_min, sh_er_max, sh_or_min, sh_or_max;
    logic [14:0] off;
    logic        wr, commit;
    logic [1:0]  code;
    // window writes are only honoured while idle, so shadows are frozen during a check
    assign wr     = data_en & data_wr & ~dma_en & (state == IDLE);
    assign off    = data_addr[15:1] - META_BASE[15:1];
    assign commit = wr & (off == 15'd4) & data_wdata[0];
    always_comb
        code = idx == 2'd0 ? (sh_er_min > sh_er_max ? 2'd1 : 2'd0) :
               idx == 2'd1 ? (sh_or_min > sh_or_max ? 2'd1 : 2'd0) :
               idx == 2'd2 ? ((sh_er_max < sh_or_min || sh_or_max < sh_er_min) ? 2'd0 : 2'd2) :
                             ((sh_er_max < SMEM_BASE || {1'b0, sh_er_min} > SMEM_END) ? 2'd0 : 2'd2);
    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            state     <= IDLE;
            idx       <= 2'd0;
            sh_er_min <= ER_MIN_DEF;
            sh_er_max <= ER_MAX_DEF;
            sh_or_min <= OR_MIN_DEF;
            sh_or_max <= OR_MAX_DEF;
            ER_min    <= ER_MIN_DEF;
            ER_max    <= ER_MAX_DEF;
            OR_min    <= OR_MIN_DEF;
            OR_max    <= OR_MAX_DEF;
            cfg_busy  <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_err   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr && off == 15'd0) sh_er_min <= data_wdata;
                    if (wr && off == 15'd1) sh_er_max <= data_wdata;
                    if (wr && off == 15'd2) sh_or_min <= data_wdata;
                    if (wr && off == 15'd3) sh_or_max <= data_wdata;
                    if (commit && exec) cfg_err <= 2'd3;
                    if (commit && !exec) begin
                        state    <= CHECK;
                        idx      <= 2'd0;
                        cfg_busy <= 1'b1;
                    end
                end
                CHECK: begin
                    if (code != 2'd0) begin
                        cfg_err  <= code;
                        cfg_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (idx == 2'd3) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                COMMIT: begin
                    if (exec) begin
                        cfg_err <= 2'd3;
                    end else begin
                        ER_min    <= sh_er_min;
                        ER_max    <= sh_er_max;
                        OR_min    <= sh_or_min;
                        OR_max    <= sh_or_max;
                        cfg_valid <= 1'b1;
                        cfg_err   <= 2'd0;
                    end
                    cfg_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apex_cfg_ctrl.sv
// tb_apex_cfg_ctrl: scoreboard bench; expected commit outcomes are queued at issue
// time and popped by a monitor whenever cfg_busy falls.
module tb_apex_cfg_ctrl;
    logic        clk = 0, puc = 1;
    logic        data_en = 0, data_wr = 0, dma_en = 0, exec = 0;
    logic [15:0] data_addr = 0, data_wdata = 0;
    logic [15:0] ER_min, ER_max, OR_min, OR_max;
    logic        cfg_busy, cfg_valid;
    logic [1:0]  cfg_err;

    apex_cfg_ctrl dut (
        .clk(clk), .puc(puc), .data_en(data_en), .data_wr(data_wr),
        .data_addr(data_addr), .data_wdata(data_wdata), .dma_en(dma_en), .exec(exec),
        .ER_min(ER_min), .ER_max(ER_max), .OR_min(OR_min), .OR_max(OR_max),
        .cfg_busy(cfg_busy), .cfg_valid(cfg_valid), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] live;
        logic        valid;
        logic [1:0]  err;
        int          blen;
    } exp_t;

    exp_t        q[$];
    int          compared = 0, mismatched = 0;
    logic [15:0] sh[4], lv[4];
    logic [15:0] defs[4];
    bit          mvalid;
    logic [1:0]  merr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    // Reference rule list: returns the error code and how many checks ran before deciding
    function automatic int ref_check(input logic [15:0] s[4], output int steps);
        int emn = s[0], emx = s[1], omn = s[2], omx = s[3];
        int smem_end = 32'hA000 + 32'h4000 - 1;
        steps = 1;
        if (emn > emx) return 1;
        steps = 2;
        if (omn > omx) return 1;
        steps = 3;
        if (!(emx < omn || omx < emn)) return 2;
        steps = 4;
        if (!(emx < 32'hA000 || emn > smem_end)) return 2;
        return 0;
    endfunction

    // monitor: counts busy cycles and checks the outcome when busy drops
    int bl = 0;
    bit pb = 0;
    always @(negedge clk) begin
        exp_t e;
        if (puc) begin
            bl = 0;
            pb = 0;
        end else begin
            if (cfg_busy) bl++;
            if (pb && !cfg_busy) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: busy fell with empty queue, err=%0d", cfg_err);
                end else begin
                    e = q.pop_front();
                    chk("live", pack4(ER_min, ER_max, OR_min, OR_max), e.live);
                    chk("valid", 64'(cfg_valid), 64'(e.valid));
                    chk("err", 64'(cfg_err), 64'(e.err));
                    chk("busy_len", 64'(bl), 64'(e.blen));
                end
                bl = 0;
            end
            pb = cfg_busy;
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit dma);
        data_en = 1; data_wr = 1; dma_en = dma; data_addr = a; data_wdata = d;
        @(posedge clk); #1;
        data_en = 0; data_wr = 0; dma_en = 0;
    endtask

    task automatic set_sh(input int k, input logic [15:0] v);
        wr(16'h0140 + 16'(2 * k) + 16'($urandom_range(0, 1)), v, 0);
        sh[k] = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (cfg_busy && n < 20);
        if (cfg_busy) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", cfg_busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_commit(input bit ex_now, input bit ex_mid);
        exp_t e;
        int code, steps;
        if (ex_now) begin
            exec = 1;
            wr(16'h0148, 16'h0001, 0);
            exec = 0;
            merr = 2'd3;
            chk("locked_err", 64'(cfg_err), 64'(merr));
            chk("locked_busy", 64'(cfg_busy), 64'd0);
            chk("locked_live", pack4(ER_min, ER_max, OR_min, OR_max), pack4(lv[0], lv[1], lv[2], lv[3]));
            return;
        end
        code = ref_check(sh, steps);
        if (code != 0) begin
            merr = 2'(code);
            e.blen = steps;
        end else if (ex_mid) begin
            merr = 2'd3;
            e.blen = 5;
        end else begin
            merr = 2'd0;
            lv = sh;
            mvalid = 1;
            e.blen = 5;
        end
        e.live = pack4(lv[0], lv[1], lv[2], lv[3]);
        e.valid = mvalid;
        e.err = merr;
        q.push_back(e);
        wr(16'h0148, 16'h0001, 0);
        if (ex_mid) exec = 1;
        wait_idle();
        exec = 0;
    endtask

    task automatic model_reset();
        sh = defs;
        lv = defs;
        mvalid = 0;
        merr = 0;
    endtask

    initial begin
        defs = '{16'hE1CC, 16'hE6CC, 16'hF000, 16'hF004};
        model_reset();
        repeat (2) @(posedge clk);
        #1 puc = 0;
        @(negedge clk);
        // reset state
        chk("rst_live", pack4(ER_min, ER_max, OR_min, OR_max), pack4(16'hE1CC, 16'hE6CC, 16'hF000, 16'hF004));
        chk("rst_flags", {61'd0, cfg_valid, cfg_err}, 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        @(posedge clk); #1;
        // legal set goes live after 5 busy cycles
        set_sh(0, 16'hC000); set_sh(1, 16'hC100); set_sh(2, 16'hF000); set_sh(3, 16'hF010);
        chk("pre_commit_live", pack4(ER_min, ER_max, OR_min, OR_max), pack4(16'hE1CC, 16'hE6CC, 16'hF000, 16'hF004));
        do_commit(0, 0);
        // inverted ER range -> RANGE at idx0
        set_sh(0, 16'hC100); set_sh(1, 16'hC000);
        do_commit(0, 0);
        // ER overlapping OR -> OVERLAP at idx2
        set_sh(0, 16'hC000); set_sh(1, 16'hF002); set_sh(2, 16'hF000); set_sh(3, 16'hF004);
        do_commit(0, 0);
        // ER touching SMEM base -> OVERLAP at idx3
        set_sh(0, 16'h9000); set_sh(1, 16'hA000);
        do_commit(0, 0);
        // equality is legal at both range checks
        set_sh(0, 16'h9FFF); set_sh(1, 16'h9FFF); set_sh(2, 16'hF002); set_sh(3, 16'hF002);
        do_commit(0, 0);
        // exec at commit is locked out; exec raised during CHECK aborts at COMMIT
        set_sh(0, 16'h1000); set_sh(1, 16'h2000);
        do_commit(1, 0);
        do_commit(0, 1);
        // CTRL bit0 clear is a no-op
        wr(16'h0148, 16'h0000, 0);
        chk("noop_busy", 64'(cfg_busy), 64'd0);
        // CPU and DMA writes mid-check are dropped; DMA write when idle is dropped too
        wr(16'h0140, 16'h0500, 1);
        begin
            exp_t e;
            int steps;
            void'(ref_check(sh, steps));
            lv = sh; mvalid = 1; merr = 0;
            e.live = pack4(lv[0], lv[1], lv[2], lv[3]); e.valid = 1; e.err = 0; e.blen = 5;
            q.push_back(e);
            wr(16'h0148, 16'h0001, 0);
            wr(16'h0140, 16'h0800, 0);
            wr(16'h0142, 16'h0900, 1);
            wait_idle();
        end
        // puc at idx2 returns everything to reset values at once
        set_sh(0, 16'h3000); set_sh(1, 16'h3100);
        wr(16'h0148, 16'h0001, 0);
        @(posedge clk); @(posedge clk); #1;
        puc = 1;
        #1;
        model_reset();
        chk("puc_live", pack4(ER_min, ER_max, OR_min, OR_max), pack4(lv[0], lv[1], lv[2], lv[3]));
        chk("puc_flags", {61'd0, cfg_busy, cfg_valid, cfg_err[0]}, 64'd0);
        chk("puc_err", 64'(cfg_err), 64'd0);
        @(negedge clk);
        @(posedge clk); #1 puc = 0;
        // randomized commits, including unmapped offsets and DMA traffic
        for (int it = 0; it < 60; it++) begin
            logic [15:0] v[4];
            if ($urandom_range(0, 1) == 1) begin
                v[0] = 16'($urandom_range(0, 16'h8FFF));
                v[1] = v[0] + 16'($urandom_range(0, 16'h0FFF));
                v[2] = 16'($urandom_range(16'hE000, 16'hEFFF));
                v[3] = v[2] + 16'($urandom_range(0, 16'h00FF));
                if ($urandom_range(0, 3) == 0) begin
                    logic [15:0] t;
                    t = v[0]; v[0] = v[1]; v[1] = t;
                end
            end else begin
                for (int k = 0; k < 4; k++) v[k] = 16'($urandom_range(0, 16'hFFFF));
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) wr(16'h0140 + 16'(2 * k), v[k] ^ 16'h5A5A, 1);
                if ($urandom_range(0, 4) != 0) set_sh(k, v[k]);
            end
            if ($urandom_range(0, 3) == 0) wr(16'h014A + 16'(2 * $urandom_range(0, 2)), 16'($urandom), 0);
            do_commit($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
